cobra_sys_bus: RTL and testbench
================================

// Module: cobra_sys_bus
// PURPOSE
//  Parametrised Z80 system-bus controller between a tv80s core, the memory
//  module and up to 8 I/O peripherals. Decodes ROM/RAM/I-O cycles, inserts
//  programmable wait states, generates single-cycle I/O strobes and implements
//  an edge-latched, maskable interrupt controller (IM1, int_n aggregate).
// PARAMETERS
//  ROM_TOP   16'h2000  first RAM address; addr < ROM_TOP is ROM (read-only)
//  MEM_WAIT  1         wait cycles inserted per memory cycle (0..15)
//  IO_WAIT   2         wait cycles inserted per I/O cycle (0..15)
//  N_IRQ     4         interrupt source count (1..8)
//  IRQ_PORT  8'hF0     I/O port of the interrupt mask/pending register
// PORTS
//  clk        in   1      system clock
//  reset      in   1      synchronous, active-high reset
//  cpu_addr   in   16     CPU address bus A
//  cpu_dout   in   8      CPU write data
//  cpu_din    out  8      CPU read data (di)
//  cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_m1_n, cpu_rfsh_n  in 1 each
//  cpu_wait_n out  1      wait request to core
//  cpu_int_n  out  1      maskable interrupt request to core
//  mem_addr   out  16     memory address (= cpu_addr)
//  mem_wdata  out  8      memory write data (= cpu_dout)
//  mem_rdata  in   8      memory read data
//  mem_rd     out  1      memory read enable
//  mem_wr     out  1      memory write enable
//  rom_wr_err out  1      1-cycle pulse: write attempted into ROM region
//  io_port    out  8      I/O port number (= cpu_addr[7:0])
//  io_rd      out  1      1-cycle I/O read strobe
//  io_wr      out  1      1-cycle I/O write strobe
//  io_rdata   in   8      I/O read data from peripherals
//  irq_in     in   N_IRQ  interrupt sources, rising-edge sensitive
// BEHAVIOUR
//  Reset: cpu_wait_n=1, cpu_int_n=1, mem_rd=mem_wr=0, io_rd=io_wr=0,
//   rom_wr_err=0, wait counter=0, pending=0, mask=0, irq_in history=0.
//  Cycle types (combinational): MEM = ~mreq_n & rfsh_n; REFRESH = ~mreq_n &
//   ~rfsh_n (ignored, no waits, no enables); IO = ~iorq_n & m1_n;
//   ACK = ~iorq_n & ~m1_n.
//  mem_rd = MEM & ~rd_n. mem_wr = MEM & ~wr_n & (cpu_addr >= ROM_TOP).
//  rom_wr_err pulses once per cycle when MEM & ~wr_n & addr < ROM_TOP.
//  Wait FSM: IDLE -> WAIT on first clk where MEM or IO is active and was not
//   active the previous clk; loads counter with MEM_WAIT/IO_WAIT. In WAIT,
//   cpu_wait_n=0 while counter!=0, decrement each clk. counter==0 -> DONE;
//   DONE holds until cycle ends (mreq_n & iorq_n high) -> IDLE. Load value 0
//   goes straight to DONE, cpu_wait_n never drops.
//  io_rd/io_wr: exactly one pulse per IO cycle, on the clk entering DONE;
//   never on ACK cycles. Accesses to IRQ_PORT are internal: no strobe.
//  IRQ port: IO write -> mask <= cpu_dout[N_IRQ-1:0]; IO read -> pending,
//   zero-extended.
//  Interrupts: irq_in registered; rising edge sets pending[i].
//   cpu_int_n = ~|(pending & mask). On first clk of ACK, clear lowest-index
//   bit of (pending & mask); cpu_din=8'hFF during ACK. Edge on the same bit
//   in the ack clk: set wins (stays pending). Masked bits still latch.
//  cpu_din mux: ACK 8'hFF; IO to IRQ_PORT pending; other IO io_rdata;
//   else mem_rdata.
//  Reset mid-cycle: FSM to IDLE and wait_n=1 next clk; cycle in progress is
//   not re-detected as new until cpu strobes deassert.
// TESTING
//  MEM_WAIT=1: read 16'h3000 -> wait_n low exactly 1 clk, mem_rd high,
//   cpu_din=mem_rdata; refresh cycle -> no wait, mem_rd=0.
//  Write 16'h0100 (ROM_TOP=16'h2000) -> mem_wr stays 0, rom_wr_err 1 clk;
//   write 16'h2000 -> mem_wr=1, no error.
//  IO_WAIT=2: OUT (8'h10),8'h5A -> wait_n low 2 clks, single io_wr pulse,
//   io_port=8'h10; IN from IRQ_PORT -> no io_rd pulse.
//  mask=4'b0110, pulse irq_in[2] then irq_in[1] -> int_n=0; ACK clears bit1,
//   int_n stays 0; second ACK clears bit2 -> int_n=1; reads pending=0.
//  irq_in[0] edge while masked -> int_n=1, pending=8'h01; write mask=1 ->
//   int_n=0 next clk. Reset asserted during wait -> wait_n=1 next clk.

Source files
------------

// File: rtl/cobra_sys_bus_if.sv
// System-bus bundle between the tv80s core, memory, I/O peripherals and the
// cobra_sys_bus controller. The master side drives the CPU strobes and the
// peripheral return data; the slave side is the bus controller.
interface cobra_sys_bus_if #(
  parameter int N_IRQ = 4
);
  logic [15:0]      cpu_addr;
  logic [7:0]       cpu_dout;
  logic [7:0]       cpu_din;
  logic             cpu_mreq_n;
  logic             cpu_iorq_n;
  logic             cpu_rd_n;
  logic             cpu_wr_n;
  logic             cpu_m1_n;
  logic             cpu_rfsh_n;
  logic             cpu_wait_n;
  logic             cpu_int_n;
  logic [15:0]      mem_addr;
  logic [7:0]       mem_wdata;
  logic [7:0]       mem_rdata;
  logic             mem_rd;
  logic             mem_wr;
  logic             rom_wr_err;
  logic [7:0]       io_port;
  logic             io_rd;
  logic             io_wr;
  logic [7:0]       io_rdata;
  logic [N_IRQ-1:0] irq_in;

  modport master (
    output cpu_addr, cpu_dout, cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n,
           cpu_m1_n, cpu_rfsh_n, mem_rdata, io_rdata, irq_in,
    input  cpu_din, cpu_wait_n, cpu_int_n, mem_addr, mem_wdata, mem_rd,
           mem_wr, rom_wr_err, io_port, io_rd, io_wr
  );

  modport slave (
    input  cpu_addr, cpu_dout, cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n,
           cpu_m1_n, cpu_rfsh_n, mem_rdata, io_rdata, irq_in,
    output cpu_din, cpu_wait_n, cpu_int_n, mem_addr, mem_wdata, mem_rd,
           mem_wr, rom_wr_err, io_port, io_rd, io_wr
  );
endinterface

// File: rtl/cobra_sys_bus.sv
// Z80 system-bus controller: ROM/RAM/I-O decode, programmable wait states,
// single-cycle I/O strobes and an edge-latched maskable interrupt controller
// (IM1, aggregate int_n) with its mask/pending register on IRQ_PORT.
module cobra_sys_bus #(
  parameter logic [15:0] ROM_TOP  = 16'h2000,
  parameter int          MEM_WAIT = 1,
  parameter int          IO_WAIT  = 2,
  parameter int          N_IRQ    = 4,
  parameter logic [7:0]  IRQ_PORT = 8'hF0
) (
  input logic             clk,
  input logic             reset,
  cobra_sys_bus_if.slave  bus
);

  localparam logic [3:0] MEM_LD = 4'(MEM_WAIT);
  localparam logic [3:0] IO_LD  = 4'(IO_WAIT);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

  state_t           state, state_nxt;
  logic [3:0]       wait_cnt;
  logic [3:0]       load_val;
  logic             mem_cyc, io_cyc, ack_cyc, active, active_q, start;
  logic             enter_done, irq_sel, rom_bad, err_seen;
  logic             io_rd_q, io_wr_q, rom_err_q, ack_q;
  logic             wait_n;
  logic [N_IRQ-1:0] irq_q, rise, pending, mask, pm, ack_clr;
  logic [7:0]       pend8, din_mux;

  // Cycle classification; refresh (mreq with rfsh low) falls into none of these
  assign mem_cyc  = ~bus.cpu_mreq_n & bus.cpu_rfsh_n;
  assign io_cyc   = ~bus.cpu_iorq_n & bus.cpu_m1_n;
  assign ack_cyc  = ~bus.cpu_iorq_n & ~bus.cpu_m1_n;
  assign active   = mem_cyc | io_cyc;
  assign start    = active & ~active_q;
  assign load_val = io_cyc ? IO_LD : MEM_LD;
  assign irq_sel  = (bus.cpu_addr[7:0] == IRQ_PORT);
  assign rom_bad  = mem_cyc & ~bus.cpu_wr_n & (bus.cpu_addr < ROM_TOP);

  assign enter_done = (state != ST_DONE) && (state_nxt == ST_DONE);

  // Lowest-index enabled pending source, cleared on the first clock of an ack
  assign pm      = pending & mask;
  assign ack_clr = (ack_cyc & ~ack_q) ? (pm & (~pm + N_IRQ'(1))) : '0;
  assign rise    = bus.irq_in & ~irq_q;

  // Wait FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Wait FSM next state; a cycle is over once neither MEM nor IO is active
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = (load_val == 4'd0) ? ST_DONE : ST_WAIT;
      ST_WAIT: if (wait_cnt <= 4'd1) state_nxt = ST_DONE;
      ST_DONE: if (!active) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Wait FSM outputs
  always_comb begin
    wait_n = 1'b1;
    if (state == ST_WAIT && wait_cnt != 4'd0) wait_n = 1'b0;
  end

  // Wait counter and previous-clock activity; during reset the activity
  // history tracks the bus so a cycle cut by reset is not seen as new
  always_ff @(posedge clk) begin
    active_q <= active;
    if (reset) begin
      wait_cnt <= 4'd0;
    end else if (state == ST_IDLE && start) begin
      wait_cnt <= load_val;
    end else if (state == ST_WAIT && wait_cnt != 4'd0) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  // I/O strobes on DONE entry and one ROM-write error pulse per cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      io_rd_q   <= 1'b0;
      io_wr_q   <= 1'b0;
      rom_err_q <= 1'b0;
      err_seen  <= 1'b0;
    end else begin
      io_rd_q   <= enter_done & io_cyc & ~bus.cpu_rd_n & ~irq_sel;
      io_wr_q   <= enter_done & io_cyc & ~bus.cpu_wr_n & ~irq_sel;
      rom_err_q <= rom_bad & ~err_seen;
      err_seen  <= mem_cyc & (err_seen | rom_bad);
    end
  end

  // Interrupt history, pending (set beats ack-clear) and mask register
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q   <= '0;
      pending <= '0;
      mask    <= '0;
      ack_q   <= 1'b0;
    end else begin
      irq_q   <= bus.irq_in;
      ack_q   <= ack_cyc;
      pending <= (pending & ~ack_clr) | rise;
      if (enter_done & io_cyc & ~bus.cpu_wr_n & irq_sel)
        mask <= bus.cpu_dout[N_IRQ-1:0];
    end
  end

  // CPU read-data mux: ack vector, internal pending register, I/O, memory
  always_comb begin
    pend8 = '0;
    pend8[N_IRQ-1:0] = pending;
    din_mux = bus.mem_rdata;
    if (ack_cyc)               din_mux = 8'hFF;
    else if (io_cyc && irq_sel) din_mux = pend8;
    else if (io_cyc)           din_mux = bus.io_rdata;
  end

  assign bus.cpu_din    = din_mux;
  assign bus.cpu_wait_n = wait_n;
  assign bus.cpu_int_n  = ~|pm;
  assign bus.mem_addr   = bus.cpu_addr;
  assign bus.mem_wdata  = bus.cpu_dout;
  assign bus.mem_rd     = mem_cyc & ~bus.cpu_rd_n;
  assign bus.mem_wr     = mem_cyc & ~bus.cpu_wr_n & (bus.cpu_addr >= ROM_TOP);
  assign bus.rom_wr_err = rom_err_q;
  assign bus.io_port    = bus.cpu_addr[7:0];
  assign bus.io_rd      = io_rd_q;
  assign bus.io_wr      = io_wr_q;

endmodule

// File: tb/tb_cobra_sys_bus.sv
// Bench for cobra_sys_bus: directed scenarios followed by randomized bus,
// interrupt and acknowledge traffic checked against a transaction-level model.
module tb_cobra_sys_bus;

  localparam logic [15:0] ROM_TOP  = 16'h2000;
  localparam int          MEM_WAIT = 1;
  localparam int          IO_WAIT  = 2;
  localparam int          N_IRQ    = 4;
  localparam logic [7:0]  IRQ_PORT = 8'hF0;
  localparam int          HOLD     = 8;

  localparam int K_MRD = 0, K_MWR = 1, K_IORD = 2, K_IOWR = 3, K_RFSH = 4;

  logic clk = 1'b0;
  logic reset;

  cobra_sys_bus_if #(.N_IRQ(N_IRQ)) bus ();

  cobra_sys_bus #(
    .ROM_TOP(ROM_TOP), .MEM_WAIT(MEM_WAIT), .IO_WAIT(IO_WAIT),
    .N_IRQ(N_IRQ), .IRQ_PORT(IRQ_PORT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: interrupt controller state as plain bit sets
  logic [N_IRQ-1:0] m_pending = '0;
  logic [N_IRQ-1:0] m_mask    = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic m_int_n();
    return ((m_pending & m_mask) == '0);
  endfunction

  task automatic bus_idle();
    bus.cpu_mreq_n = 1'b1;
    bus.cpu_iorq_n = 1'b1;
    bus.cpu_rd_n   = 1'b1;
    bus.cpu_wr_n   = 1'b1;
    bus.cpu_m1_n   = 1'b1;
    bus.cpu_rfsh_n = 1'b1;
    bus.irq_in     = '0;
  endtask

  // One complete CPU bus cycle held for HOLD clocks, then released
  task automatic bus_cycle(input int kind, input logic [15:0] addr,
                           input logic [7:0] data, output logic [7:0] din_o);
    int waits = 0, iord = 0, iowr = 0, errs = 0, memrd = 0, memwr = 0;
    logic [7:0] port_seen = 8'h00;
    logic [7:0] mdat, idat, wdat_seen;
    logic [15:0] maddr_seen;
    logic is_irq_port, is_rom;
    int exp_waits;
    mdat = 8'($urandom);
    idat = 8'($urandom);
    bus.mem_rdata = mdat;
    bus.io_rdata  = idat;
    bus.cpu_addr  = addr;
    bus.cpu_dout  = data;
    case (kind)
      K_MRD:  begin bus.cpu_mreq_n = 1'b0; bus.cpu_rd_n = 1'b0; end
      K_MWR:  begin bus.cpu_mreq_n = 1'b0; bus.cpu_wr_n = 1'b0; end
      K_IORD: begin bus.cpu_iorq_n = 1'b0; bus.cpu_rd_n = 1'b0; end
      K_IOWR: begin bus.cpu_iorq_n = 1'b0; bus.cpu_wr_n = 1'b0; end
      default: begin bus.cpu_mreq_n = 1'b0; bus.cpu_rfsh_n = 1'b0; end
    endcase
    for (int i = 0; i < HOLD; i++) begin
      tick();
      if (!bus.cpu_wait_n) waits++;
      if (bus.io_rd) begin iord++; port_seen = bus.io_port; end
      if (bus.io_wr) begin iowr++; port_seen = bus.io_port; end
      if (bus.rom_wr_err) errs++;
      if (bus.mem_rd) memrd++;
      if (bus.mem_wr) memwr++;
    end
    din_o      = bus.cpu_din;
    maddr_seen = bus.mem_addr;
    wdat_seen  = bus.mem_wdata;
    bus_idle();
    tick();
    tick();

    is_irq_port = (addr[7:0] == IRQ_PORT);
    is_rom      = (addr < ROM_TOP);
    exp_waits   = (kind == K_MRD || kind == K_MWR) ? MEM_WAIT :
                  (kind == K_IORD || kind == K_IOWR) ? IO_WAIT : 0;
    check("wait_clks", waits, exp_waits);
    check("mem_rd_clks", memrd, (kind == K_MRD) ? HOLD : 0);
    check("mem_wr_clks", memwr, (kind == K_MWR && !is_rom) ? HOLD : 0);
    check("rom_wr_err_pulses", errs, (kind == K_MWR && is_rom) ? 1 : 0);
    check("io_rd_pulses", iord, (kind == K_IORD && !is_irq_port) ? 1 : 0);
    check("io_wr_pulses", iowr, (kind == K_IOWR && !is_irq_port) ? 1 : 0);
    if ((kind == K_IORD || kind == K_IOWR) && !is_irq_port)
      check("io_port", port_seen, addr[7:0]);
    if (kind == K_MRD) check("din_mem", din_o, mdat);
    if (kind == K_MWR) begin
      check("mem_addr", maddr_seen, addr);
      check("mem_wdata", wdat_seen, data);
    end
    if (kind == K_IORD)
      check("din_io", din_o, is_irq_port ? {4'h0, m_pending} : idat);
    if (kind == K_IOWR && is_irq_port) m_mask = data[N_IRQ-1:0];
    check("int_n_after_cycle", bus.cpu_int_n, m_int_n());
  endtask

  // Interrupt acknowledge, with optional edges arriving in the ack clock
  task automatic ack_cycle(input logic [N_IRQ-1:0] edge_bits);
    int waits = 0, strobes = 0;
    logic [7:0] din_seen;
    logic [N_IRQ-1:0] en;
    bus.cpu_iorq_n = 1'b0;
    bus.cpu_m1_n   = 1'b0;
    bus.irq_in     = edge_bits;
    tick();
    bus.irq_in = '0;
    for (int i = 0; i < 3; i++) begin
      if (!bus.cpu_wait_n) waits++;
      if (bus.io_rd || bus.io_wr) strobes++;
      tick();
    end
    din_seen = bus.cpu_din;
    bus_idle();
    tick();
    en = m_pending & m_mask;
    for (int b = 0; b < N_IRQ; b++) begin
      if (en[b]) begin
        m_pending[b] = 1'b0;
        break;
      end
    end
    m_pending = m_pending | edge_bits;
    check("ack_waits", waits, 0);
    check("ack_strobes", strobes, 0);
    check("ack_din", din_seen, 8'hFF);
    check("int_n_after_ack", bus.cpu_int_n, m_int_n());
  endtask

  task automatic irq_pulse(input logic [N_IRQ-1:0] bits);
    bus.irq_in = bits;
    tick();
    bus.irq_in = '0;
    tick();
    m_pending = m_pending | bits;
    check("int_n_after_irq", bus.cpu_int_n, m_int_n());
  endtask

  initial begin
    logic [7:0]  din;
    logic [15:0] a;
    logic [7:0]  d;
    int          op;
    int          rst_bad;

    reset = 1'b1;
    bus.cpu_addr  = 16'h0000;
    bus.cpu_dout  = 8'h00;
    bus.mem_rdata = 8'h00;
    bus.io_rdata  = 8'h00;
    bus_idle();
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_wait_n", bus.cpu_wait_n, 1'b1);
    check("rst_int_n", bus.cpu_int_n, 1'b1);
    check("rst_mem_rd", bus.mem_rd, 1'b0);
    check("rst_mem_wr", bus.mem_wr, 1'b0);
    check("rst_io_rd", bus.io_rd, 1'b0);
    check("rst_io_wr", bus.io_wr, 1'b0);
    check("rst_rom_wr_err", bus.rom_wr_err, 1'b0);

    // Memory, refresh and ROM-protection boundaries
    bus_cycle(K_MRD, 16'h3000, 8'h00, din);
    bus_cycle(K_RFSH, 16'h0042, 8'h00, din);
    bus_cycle(K_MWR, 16'h0100, 8'hA5, din);
    bus_cycle(K_MWR, 16'h2000, 8'h3C, din);
    bus_cycle(K_MWR, 16'h1FFF, 8'h11, din);

    // I/O strobes and the internal interrupt port
    bus_cycle(K_IOWR, 16'h0010, 8'h5A, din);
    bus_cycle(K_IORD, 16'h00F0, 8'h00, din);
    check("irqport_rd_zero", din, 8'h00);

    // Masked priority clearing by successive acks
    bus_cycle(K_IOWR, 16'h00F0, 8'h06, din);
    irq_pulse(4'b0100);
    irq_pulse(4'b0010);
    check("int_n_two_pending", bus.cpu_int_n, 1'b0);
    ack_cycle('0);
    check("int_n_after_ack1", bus.cpu_int_n, 1'b0);
    ack_cycle('0);
    check("int_n_after_ack2", bus.cpu_int_n, 1'b1);
    bus_cycle(K_IORD, 16'h00F0, 8'h00, din);
    check("pending_cleared", din, 8'h00);

    // Masked sources still latch; unmasking raises int_n
    irq_pulse(4'b0001);
    check("int_n_masked", bus.cpu_int_n, 1'b1);
    bus_cycle(K_IORD, 16'h00F0, 8'h00, din);
    check("pending_masked", din, 8'h01);
    bus_cycle(K_IOWR, 16'h00F0, 8'h01, din);
    check("int_n_unmasked", bus.cpu_int_n, 1'b0);
    ack_cycle('0);

    // Edge in the ack clock on the bit being cleared keeps it pending
    bus_cycle(K_IOWR, 16'h00F0, 8'h02, din);
    irq_pulse(4'b0010);
    ack_cycle(4'b0010);
    check("set_wins_int_n", bus.cpu_int_n, 1'b0);
    ack_cycle('0);

    // Reset during a wait releases wait_n and the cut cycle is not restarted
    bus.cpu_addr   = 16'h0044;
    bus.cpu_dout   = 8'h77;
    bus.cpu_iorq_n = 1'b0;
    bus.cpu_wr_n   = 1'b0;
    tick();
    check("pre_rst_wait_n", bus.cpu_wait_n, 1'b0);
    reset = 1'b1;
    tick();
    check("rst_mid_wait_n", bus.cpu_wait_n, 1'b1);
    reset = 1'b0;
    rst_bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (!bus.cpu_wait_n || bus.io_wr) rst_bad++;
    end
    check("no_restart_after_rst", rst_bad, 0);
    bus_idle();
    tick();
    tick();
    m_pending = '0;
    m_mask    = '0;
    check("rst_mid_int_n", bus.cpu_int_n, 1'b1);

    // Randomized traffic against the model
    for (int n = 0; n < 200; n++) begin
      op = $urandom_range(0, 7);
      a  = 16'($urandom);
      d  = 8'($urandom);
      case (op)
        0: bus_cycle(K_MRD, a, d, din);
        1: begin
             if ($urandom_range(0, 1) == 0) a = 16'($urandom_range(0, 32'h1FFF));
             bus_cycle(K_MWR, a, d, din);
           end
        2, 3: begin
             if ($urandom_range(0, 2) == 0) a[7:0] = IRQ_PORT;
             bus_cycle((op == 2) ? K_IORD : K_IOWR, a, d, din);
           end
        4: bus_cycle(K_RFSH, a, d, din);
        5: irq_pulse(N_IRQ'($urandom));
        6: ack_cycle(($urandom_range(0, 3) == 0) ? N_IRQ'($urandom) : '0);
        default: bus_cycle(K_IOWR, {a[15:8], IRQ_PORT}, d, din);
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Run-length guard so the bench always ends
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1, "timeout");
  end

endmodule
